// File: rtl/mac_tile_reduction.sv
// MAC-mode tile reduction: accumulates partial-sum tiles across beats, row-sums each closed
// tile, rounds/requantizes to DATA_WIDTH and queues the vector in a small valid/ready FIFO.
module mac_tile_reduction #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int SUM_WIDTH  = 40,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      mac_mode,
  input  logic                                                      valid_in,
  input  logic                                                      done_tile,
  input  logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] tile_in,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]               out_vec,
  output logic                                                      out_sat,
  output logic [7:0]                                                beat_cnt,
  output logic                                                      overflow_err
);

  localparam int RS_W  = SUM_WIDTH + $clog2(TILE_SIZE);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};
  localparam logic signed [RS_W:0] HALF  = {{(RS_W+1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [RS_W:0] R_MAX = {{(RS_W+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RS_W:0] R_MIN = {{(RS_W+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic signed [SUM_WIDTH-1:0] sat_add(input logic signed [SUM_WIDTH-1:0] a,
                                                          input logic signed [ACC_WIDTH-1:0] b);
    logic signed [SUM_WIDTH:0] s;
    s = $signed({a[SUM_WIDTH-1], a}) + (SUM_WIDTH+1)'(b);
    if (s[SUM_WIDTH] != s[SUM_WIDTH-1])
      return s[SUM_WIDTH] ? SUM_MIN : SUM_MAX;
    return s[SUM_WIDTH-1:0];
  endfunction

  // Round half toward +inf, then clip to DATA_WIDTH; MSB of the result flags a clip.
  function automatic logic [DATA_WIDTH:0] requant(input logic signed [RS_W-1:0] x);
    logic signed [RS_W:0] r;
    r = ($signed({x[RS_W-1], x}) + HALF) >>> FRAC_BITS;
    if (r > R_MAX) return {1'b1, R_MAX[DATA_WIDTH-1:0]};
    if (r < R_MIN) return {1'b1, R_MIN[DATA_WIDTH-1:0]};
    return {1'b0, r[DATA_WIDTH-1:0]};
  endfunction

  logic signed [SUM_WIDTH-1:0] acc     [TILE_SIZE][TILE_SIZE];
  logic signed [SUM_WIDTH-1:0] snap_p1 [TILE_SIZE][TILE_SIZE];
  logic                        vld_p1;
  logic signed [RS_W-1:0]      row_sum    [TILE_SIZE];
  logic signed [RS_W-1:0]      row_sum_p2 [TILE_SIZE];
  logic                        vld_p2;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] q_vec;
  logic                                 q_sat;

  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] mem_vec [OUT_DEPTH];
  logic                                 mem_sat [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop, push, drop;

  // Accumulator: a beat arriving with done_tile opens the next tile
  always_ff @(posedge clk) begin
    if (rst || !mac_mode) begin
      for (int i = 0; i < TILE_SIZE; i++)
        for (int j = 0; j < TILE_SIZE; j++)
          acc[i][j] <= '0;
      beat_cnt <= '0;
    end else if (done_tile) begin
      for (int i = 0; i < TILE_SIZE; i++)
        for (int j = 0; j < TILE_SIZE; j++)
          acc[i][j] <= valid_in ? SUM_WIDTH'($signed(tile_in[i][j])) : '0;
      beat_cnt <= valid_in ? 8'd1 : 8'd0;
    end else if (valid_in) begin
      for (int i = 0; i < TILE_SIZE; i++)
        for (int j = 0; j < TILE_SIZE; j++)
          acc[i][j] <= sat_add(acc[i][j], $signed(tile_in[i][j]));
      if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
    end
  end

  // Stage 1 boundary: tile snapshot
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= done_tile & mac_mode;
  end

  always_ff @(posedge clk) begin
    if (done_tile && mac_mode) snap_p1 <= acc;
  end

  always_comb begin
    for (int i = 0; i < TILE_SIZE; i++) begin
      row_sum[i] = '0;
      for (int j = 0; j < TILE_SIZE; j++)
        row_sum[i] = row_sum[i] + RS_W'(snap_p1[i][j]);
    end
  end

  // Stage 2 boundary: row sums
  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) row_sum_p2 <= row_sum;
  end

  always_comb begin
    logic [DATA_WIDTH:0] rq;
    q_vec = '0;
    q_sat = 1'b0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      rq       = requant(row_sum_p2[i]);
      q_vec[i] = rq[DATA_WIDTH-1:0];
      q_sat    = q_sat | rq[DATA_WIDTH];
    end
  end

  // Output FIFO boundary: a pop in the same cycle frees room for the push
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = vld_p2 & ((count != CNT_W'(OUT_DEPTH)) | pop);
  assign drop      = vld_p2 & ~push;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_vec[wr_ptr] <= q_vec;
      mem_sat[wr_ptr] <= q_sat;
    end
  end

  assign out_vec = out_valid ? mem_vec[rd_ptr] : '0;
  assign out_sat = out_valid & mem_sat[rd_ptr];

endmodule
